// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the ALU control decoder.
//   ALU_CTRL_W          : width of the alu_control code
//   ALU_ADD .. ALU_SRA  : alu_control encodings (0-7), shared with the decoder
//   ST_IDLE/SHIFT/DONE  : state encoding of the execute unit FSM
//   is_shift_op()       : true for the three codes handled by the serial shifter
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 3'd7;

  // FSM encoding kept as plain constants so older decoder/debug code that
  // compares raw state bits keeps working.
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

  // Shifts are the only multi-cycle operations; everything else is one cycle.
  function automatic logic is_shift_op(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// ---------------------------------------------------------------------------
// alu_logic_core
// Purely combinational single-cycle ALU operations.
//   alu_control : operation code (ADD, SUB, AND, OR, SLT handled here)
//   op_a, op_b  : WIDTH-bit operands
//   result      : WIDTH-bit result; shift codes yield 0 (the serial shifter
//                 in the top level produces those results)
// ---------------------------------------------------------------------------
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  output logic [WIDTH-1:0]      result
);

  logic less_signed;

  // Signed compare for SLT; ADD/SUB simply wrap with no overflow flag.
  assign less_signed = $signed(op_a) < $signed(op_b);

  // Operation select. Shift codes fall through to zero because the top level
  // never takes this result for a shift with a non-zero amount.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, less_signed};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU with valid/ready handshakes. ADD/SUB/AND/OR/SLT finish in
// one cycle; SLL/SRL/SRA run through a bit-serial shifter, one position per
// cycle, stalling the input side while in flight.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   in_valid    : operands and alu_control valid
//   in_ready    : unit accepts an operation this cycle
//   alu_control : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 SRA
//   op_a, op_b  : operands; shift amount is op_b[SHAMT_W-1:0]
//   out_valid   : result valid
//   out_ready   : downstream accepts the result
//   result      : registered result
//   zero        : registered (result == 0) flag for branch compares
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero
);

  localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

  logic [ST_W-1:0]       state_q;
  logic [WIDTH-1:0]      shift_q;
  logic [SHAMT_W-1:0]    count_q;
  logic [ALU_CTRL_W-1:0] shift_op_q;
  logic [WIDTH-1:0]      result_q;
  logic                  zero_q;

  logic [WIDTH-1:0]      core_result;
  logic [WIDTH-1:0]      single_result;
  logic [WIDTH-1:0]      shift_next;
  logic [SHAMT_W-1:0]    shamt;
  logic                  accept;
  logic                  start_shift;

  alu_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .result     (core_result)
  );

  // Handshake: in_ready depends only on state and out_ready so it never forms
  // a combinational loop with the upstream in_valid. Leaving DONE with
  // out_ready high frees the slot for a back-to-back accept on the same edge.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  // Upper op_b bits are deliberately dropped from the shift amount.
  assign shamt       = op_b[SHAMT_W-1:0];
  assign start_shift = is_shift_op(alu_control) && (shamt != '0);

  // A shift by zero is just a pass-through of op_a, so it completes in one
  // cycle like the logic ops instead of entering the serial shifter.
  always_comb begin
    single_result = core_result;
    if (is_shift_op(alu_control)) begin
      single_result = op_a;
    end
  end

  // One-position step of the serial shifter. SRA copies the current MSB,
  // which is still the MSB captured at accept because right shifts keep it.
  always_comb begin
    shift_next = shift_q;
    case (shift_op_q)
      ALU_SLL: shift_next = {shift_q[WIDTH-2:0], 1'b0};
      ALU_SRL: shift_next = {1'b0, shift_q[WIDTH-1:1]};
      default: shift_next = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
    endcase
  end

  // Main FSM with shift register, counter and output register. Reset aborts
  // any shift in flight and clears the result so nothing stale is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      shift_op_q <= ALU_SLL;
      result_q   <= '0;
      zero_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (start_shift) begin
              shift_q    <= op_a;
              count_q    <= shamt;
              shift_op_q <= alu_control;
              state_q    <= ST_SHIFT;
            end else begin
              result_q <= single_result;
              zero_q   <= (single_result == '0);
              state_q  <= ST_DONE;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          shift_q <= shift_next;
          count_q <= count_q - COUNT_ONE;
          if (count_q == COUNT_ONE) begin
            result_q <= shift_next;
            zero_q   <= (shift_next == '0);
            state_q  <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Scoreboard bench for alu_exec_unit. The driver pushes the model's expected
// result and latency when an operation is accepted; an independent monitor
// compares every presented result against the head of the queue.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          accept_edge;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  int   wait_cycles = 0;
  bit   seen = 0;
  int   ready_mode = 2;

  alu_exec_unit #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero)
  );

  // Free-running clock and an edge counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model straight from the instruction semantics.
  function automatic logic [31:0] modelResult(input logic [2:0] ctrl,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (ctrl)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return $unsigned($signed(a) >>> sh);
    endcase
  endfunction

  function automatic int modelLatency(input logic [2:0] ctrl, input logic [31:0] b);
    if (ctrl >= 3'd5 && (b % 32) != 0) return int'(b % 32) + 1;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  task automatic driveReady();
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  // Present one operation and hold it until accepted; the expectation is
  // queued just before the accepting edge. Returns right after that edge.
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b);
    exp_t e;
    bit   done;
    done = 0;
    @(negedge clk);
    alu_control = ctrl;
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (k != 0) @(negedge clk);
      driveReady();
      #1;
      if (in_ready) begin
        e.res = modelResult(ctrl, a, b);
        e.z = (e.res == 32'd0);
        e.accept_edge = cycle + 1;
        e.lat = modelLatency(ctrl, b);
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      driveReady();
    end
  endtask

  // After a shift is accepted with in_valid still high, in_ready must stay low
  // for n cycles, then open up once the result is waiting in DONE.
  task automatic checkBusy(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("in_ready_done", {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head,
  // including first-appearance latency, and retires on out_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (out_valid) begin
          wait_cycles = 0;
          if (sb.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            if (!seen) begin
              seen = 1;
              checkOutput("latency", cycle - e.accept_edge + 1, e.lat);
            end
            checkOutput("result", result, e.res);
            checkOutput("zero", {31'd0, zero}, {31'd0, e.z});
            if (out_ready) begin
              void'(sb.pop_front());
              seen = 0;
            end
          end
        end else if (sb.size() > 0) begin
          wait_cycles++;
          if (wait_cycles > 100) begin
            checkOutput("out_valid_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
            seen = 0;
            wait_cycles = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases first, then a randomized stream, then drain and summarize.
  initial begin
    logic [2:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    alu_control = 3'd0;
    op_a = 32'd0;
    op_b = 32'd0;
    #2;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    ready_mode = 2;
    applyStimulus(3'd0, 32'h7FFF_FFFF, 32'd1);
    applyStimulus(3'd1, 32'd0, 32'd1);
    applyStimulus(3'd1, 32'h1234, 32'h1234);
    applyStimulus(3'd4, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(3'd4, 32'd1, 32'hFFFF_FFFF);
    idleCycles(2);

    applyStimulus(3'd7, 32'h8000_0000, 32'h0000_0124);
    checkBusy(4);
    applyStimulus(3'd6, 32'h8000_0000, 32'd4);
    idleCycles(6);
    applyStimulus(3'd5, 32'd1, 32'd31);
    idleCycles(34);
    applyStimulus(3'd6, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    applyStimulus(3'd7, 32'h8000_0001, 32'd0);
    idleCycles(2);

    // Result held under backpressure while a new op waits, then same-edge
    // retire and accept.
    ready_mode = 1;
    applyStimulus(3'd0, 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_control = 3'd2;
      op_a = 32'h0000_F0F0;
      op_b = 32'h0000_FF00;
      in_valid = 1'b1;
      driveReady();
      #1;
      checkOutput("in_ready_held", {31'd0, in_ready}, 32'd0);
    end
    ready_mode = 2;
    applyStimulus(3'd2, 32'h0000_F0F0, 32'h0000_FF00);
    idleCycles(3);

    // Reset in the middle of a long shift.
    applyStimulus(3'd5, 32'h0000_0003, 32'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midreset_zero", {31'd0, zero}, 32'd1);
    sb.delete();
    seen = 0;
    wait_cycles = 0;
    @(negedge clk);
    rst = 1'b0;
    idleCycles(20);
    #1;
    checkOutput("post_reset_out_valid", {31'd0, out_valid}, 32'd0);

    // Randomized stream with random backpressure and idle gaps.
    ready_mode = 0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = ra;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      applyStimulus(rc, ra, rb);
    end

    ready_mode = 2;
    for (int k = 0; k < 200 && sb.size() != 0; k++) idleCycles(1);
    idleCycles(2);
    if (sb.size() != 0) checkOutput("drain_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
